// File: rtl/key_matrix_entry.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_entry
// Description : 4x4 active-low keypad scanner with debounce and a signed
//               6-digit decimal entry register for the seven-segment path.
// Revision    : 1.0 - initial release
// ============================================================================
module key_matrix_entry #(
    parameter int SCAN_CYC = 50000,
    parameter int DEB_CYC  = 1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        entry_done,
    output logic [19:0] data,
    output logic        seg_sign
);
    localparam int CNT_MAX = (DEB_CYC > SCAN_CYC) ? DEB_CYC : SCAN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SCAN_LAST   = CNT_W'(SCAN_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYC - 1);
    localparam logic [19:0]      DIGIT_LIMIT = 20'd100000;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic [1:0]       idx_q,        idx_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [3:0]       lat_q,        lat_d;
    logic [3:0]       key_col_q,    key_col_d;
    logic             key_valid_q,  key_valid_d;
    logic [3:0]       key_code_q,   key_code_d;
    logic             entry_done_q, entry_done_d;
    logic [19:0]      data_q,       data_d;
    logic             sign_q,       sign_d;
    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic [3:0]       press_code;
    logic [23:0]      data_wide;

    function automatic logic one_low(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    function automatic logic [3:0] key_decode(input logic [3:0] rows, input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] code;
        case (rows)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case ({r, col})
            4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
            4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
            4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
            4'hC: code = 4'd14;  4'hD: code = 4'd0;   4'hE: code = 4'd15;  default: code = 4'd13;
        endcase
        return code;
    endfunction

    assign press_code = key_decode(lat_q, idx_q);
    assign data_wide  = {4'd0, data_q};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        key_valid_d  = 1'b0;
        entry_done_d = 1'b0;
        key_code_d   = key_code_q;
        data_d       = data_q;
        sign_d       = sign_q;
        case (state_q)
            ST_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (one_low(row_sync_q)) begin
                        lat_d   = row_sync_q;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (row_sync_q != lat_q) begin
                    state_d = ST_SCAN;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    // Outputs are registered, so they rise exactly on the PRESSED cycle
                    state_d      = ST_PRESSED;
                    cnt_d        = '0;
                    key_valid_d  = 1'b1;
                    key_code_d   = press_code;
                    entry_done_d = (press_code == 4'd15);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
                if (key_code_q <= 4'd9) begin
                    if (data_q < DIGIT_LIMIT)
                        data_d = 20'((data_wide << 3) + (data_wide << 1) + 24'(key_code_q));
                end else begin
                    case (key_code_q)
                        4'd10: data_d = data_q / 20'd10;
                        4'd11: sign_d = ~sign_q;
                        4'd12: begin
                            data_d = '0;
                            sign_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (row_sync_q != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_SCAN;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        key_col_d = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            state_q      <= ST_SCAN;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            lat_q        <= 4'hF;
            key_col_q    <= 4'b1110;
            key_valid_q  <= 1'b0;
            key_code_q   <= 4'd0;
            entry_done_q <= 1'b0;
            data_q       <= 20'd0;
            sign_q       <= 1'b0;
        end else begin
            row_meta_q   <= key_row;
            row_sync_q   <= row_meta_q;
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            key_col_q    <= key_col_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            entry_done_q <= entry_done_d;
            data_q       <= data_d;
            sign_q       <= sign_d;
        end
    end

    assign key_col    = key_col_q;
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign entry_done = entry_done_q;
    assign data       = data_q;
    assign seg_sign   = sign_q;

endmodule
`default_nettype wire
